// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw asynchronous input into the clk domain,
// then accepts a new level only after it has been seen for STABLE_CYCLES
// consecutive synchronized samples. Emits one-cycle rise/fall pulses that
// line up with the first cycle of the new debounced level.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   busy_q;
    logic                   busy_d;
    logic                   s;

    // The chain shifts every cycle out of reset, independent of en, so the
    // filter always sees a current sample when it is re-enabled.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign s      = sync_q[SYNC_STAGES-1];

    // State register: synchronizer, FSM, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: any opposite sample or en=0 drops back to the
    // originating stable state, so qualification always restarts from scratch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                if (en && s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!en || !s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (en && !s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (!en || s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: outputs are registered from the upcoming state, and the
    // pulses fire only on a completed qualification, never on an abort.
    always_comb begin
        dout_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
        rise_d = (state_q == WAIT_HI) && (state_d == STABLE_HI);
        fall_d = (state_q == WAIT_LO) && (state_d == STABLE_LO);
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: table-driven directed vectors, hand-written reset and
// enable sequences, then randomized stimulus against a history-based model.
module tb_input_debouncer;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int checks = 0;
    int errors = 0;
    int hold   = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .en  (en),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Directed vector table: inputs applied before an edge, outputs expected after it.
    typedef struct packed {
        logic din;
        logic en;
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic d, input logic e, input logic o,
                       input logic r, input logic f, input logic b);
        vec_t v;
        v.din = d; v.en = e; v.dout = o; v.rise = r; v.fall = f; v.busy = b;
        vecs.push_back(v);
    endtask

    // Reference model: the synchronizer is a plain delay line of din; a level
    // change is accepted when the most recent SC samples (since the last
    // change) were all enabled and all opposite to the current level.
    bit din_hist[$];
    bit run_q[$];
    bit m_dout, m_rise, m_fall, m_busy;

    task automatic model_reset();
        din_hist = {};
        for (int i = 0; i < SS; i++) din_hist.push_back(1'b0);
        run_q  = {};
        m_dout = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit e);
        bit s;
        bit flip;
        int ones;
        s = din_hist.pop_front();
        din_hist.push_back(d);
        run_q.push_back(e && (s != m_dout));
        if (run_q.size() > SC) void'(run_q.pop_front());
        ones = 0;
        foreach (run_q[k]) if (run_q[k]) ones++;
        flip   = (ones == SC);
        m_rise = flip && !m_dout;
        m_fall = flip && m_dout;
        if (flip) begin
            m_dout = !m_dout;
            run_q  = {};
        end
        m_busy = !flip && (run_q.size() > 0) && run_q[$];
    endtask

    task automatic step_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Plain rise after reset (E0..E6)
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, (i >= 2));
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        // Plain fall from dout=1 (F0..F6)
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 0, (i >= 2));
        add(0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0);
        // Short high glitch rejected (G0..G5)
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        // Bounce train 1,0,1,1,0,1,1,1,1 then held high (H0..H11)
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0);

        // Reset state
        rst = 1'b0;
        din = 1'b0;
        en  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_dout", dout, 1'b0);
        chk("reset_rise", rise, 1'b0);
        chk("reset_fall", fall, 1'b0);
        chk("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            din = vecs[i].din;
            en  = vecs[i].en;
            step_edge();
            chk($sformatf("tbl%0d_dout", i), dout, vecs[i].dout);
            chk($sformatf("tbl%0d_rise", i), rise, vecs[i].rise);
            chk($sformatf("tbl%0d_fall", i), fall, vecs[i].fall);
            chk($sformatf("tbl%0d_busy", i), busy, vecs[i].busy);
        end

        // Asynchronous reset clears dout=1 with no clock edge
        #2 rst = 1'b0;
        #1;
        chk("async_dout_clr", dout, 1'b0);
        chk("async_busy_clr", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        din = 1'b1;

        // Reset mid-qualification (WAIT_HI, cnt=2) aborts with no pulse
        for (int k = 0; k < 4; k++) step_edge();
        chk("midq_busy_before", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midq_busy_clr", busy, 1'b0);
        chk("midq_dout_clr", dout, 1'b0);
        chk("midq_rise_clr", rise, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            step_edge();
            chk($sformatf("rel_rise_e%0d", k), rise, (k == 5));
            chk($sformatf("rel_dout_e%0d", k), dout, (k >= 5));
        end

        // en=0 while in WAIT_HI freezes the filter
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        din = 1'b1;
        en  = 1'b1;
        for (int k = 0; k < 3; k++) step_edge();
        chk("en_busy_wait", busy, 1'b1);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step_edge();
            chk($sformatf("en0_busy_%0d", k), busy, 1'b0);
            chk($sformatf("en0_dout_%0d", k), dout, 1'b0);
            chk($sformatf("en0_rise_%0d", k), rise, 1'b0);
        end
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step_edge();
            chk($sformatf("en1_busy_%0d", k), busy, (k < 4));
            chk($sformatf("en1_rise_%0d", k), rise, (k == 4));
            chk($sformatf("en1_dout_%0d", k), dout, (k == 4));
        end

        // Randomized run against the reference model
        rst = 1'b0;
        din = 1'b0;
        en  = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) begin
                #2 rst = 1'b0;
                model_reset();
                #1;
                chk("rnd_rst_dout", dout, m_dout);
                chk("rnd_rst_busy", busy, m_busy);
                @(negedge clk);
                rst = 1'b1;
            end
            if (hold == 0) begin
                din  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 7);
            end
            hold--;
            en = ($urandom_range(0, 15) != 0);
            @(posedge clk);
            model_step(din, en);
            @(negedge clk);
            chk("rnd_dout", dout, m_dout);
            chk("rnd_rise", rise, m_rise);
            chk("rnd_fall", fall, m_fall);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_rise_fall_excl", rise & fall, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions a raw asynchronous input (push-button, switch, external pin) into a clean, single-clock-domain level, plus one-cycle rise/fall pulses. It is the stage directly upstream of the D flip-flop and register stages: its dout drives their d input, and its pulses drive load or enable strobes. It combines a multi-stage synchronizer with a counter-based stability filter.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal range >= 2.
STABLE_CYCLES, 16, number of consecutive identical synchronized samples required to accept a new level; legal range >= 2.
CNT_W, $clog2(STABLE_CYCLES), derived local width of the stability counter; not overridable.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-low; clears all state.
din  input  1  raw asynchronous input; no timing relationship to clk.
en  input  1  filter enable; when 0, the output is frozen.
dout  output  1  debounced, synchronized level.
rise  output  1  one-cycle pulse when dout goes 0->1.
fall  output  1  one-cycle pulse when dout goes 1->0.
busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset: rst=0 asynchronously clears the following, independent of clk:
  - sync chain to all 0
  - FSM to STABLE_LO
  - counter to 0
  - dout, rise, fall, busy to 0
- Reset held low mid-qualification aborts the qualification; no pulse is emitted.
- Synchronizer:
  - sync[0] <= din; sync[i] <= sync[i-1].
  - s = sync[SYNC_STAGES-1]; the FSM samples only s.
  - The chain runs whenever rst=1, regardless of en.
- FSM states (all outputs registered):
  - STABLE_LO (dout=0): on s=1 and en=1, go to WAIT_HI with cnt<=1.
  - WAIT_HI (busy=1):
    - s=0: return to STABLE_LO, cnt<=0 (glitch rejected, no pulse).
    - else cnt==STABLE_CYCLES-1: go to STABLE_HI, dout<=1, rise<=1, cnt<=0.
    - else cnt<=cnt+1.
  - STABLE_HI (dout=1): on s=0 and en=1, go to WAIT_LO with cnt<=1.
  - WAIT_LO: mirror of WAIT_HI. On qualification, dout<=0 and fall<=1. On bounce (s=1), return to STABLE_HI.
- Pulses:
  - rise and fall are high for exactly one clk, coincident with the first cycle of the new dout value.
  - rise and fall are never high simultaneously.
- Qualification rule: a change needs STABLE_CYCLES consecutive samples of the new value. Any opposite sample restarts qualification from the stable state.
- Latency: if din changes and stays stable from before edge E0, dout and the pulse are visible after edge E(SYNC_STAGES+STABLE_CYCLES-1). With defaults this is E17.
- en=0:
  - Any WAIT state returns to its originating stable state; cnt<=0.
  - No transitions, no pulses; dout is held.
  - When en returns to 1, qualification starts fresh on the next sample.
- Counter: never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- After reset release with din already high: a normal rise pulse occurs after the full latency. This is required behaviour, not a spurious event.

Test Plan:
(Bench uses SYNC_STAGES=2, STABLE_CYCLES=4.)
1. Reset, then din 0->1 before E0, held: dout=0 and rise=0 through E4; dout=1 and rise=1 after E5; rise=0 after E6; busy high after E2..E4.
2. din high for 2 cycles, then low (bounce), din stable otherwise: busy pulses, dout stays 0, rise never asserts, FSM returns to STABLE_LO.
3. From dout=1, din 1->0 held: fall=1 for one cycle after E5, dout=0; rise stays 0 throughout.
4. Bounce train 1,0,1,1,0,1,1,1,1 (one value per clk): dout rises only after the final run of 4 consecutive synchronized 1s; exactly one rise pulse.
5. rst pulled low asynchronously (between edges) while in WAIT_HI with cnt=2: dout, busy, and cnt clear immediately with no clock; after release with din=1, rise occurs 5 edges later.
6. en=0 while in WAIT_HI, din held 1 for 10 cycles: busy=0, dout=0, no pulse; en=1, then rise after 4 further samples.
